// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared constants and types for the memory-bus arbiter.
//   ARB_NUM_MASTERS / ARB_IDX_WIDTH / ARB_HOLD_LIMIT : default geometry
//   REQ_NORMAL / REQ_PWB                             : request class encodings
//   arb_state_t                                      : arbiter FSM encodings
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int ARB_NUM_MASTERS = 4;
    localparam int ARB_IDX_WIDTH   = 2;
    localparam int ARB_HOLD_LIMIT  = 16;

    localparam logic REQ_NORMAL = 1'b0;
    localparam logic REQ_PWB    = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // Width of a counter that must reach limit-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr_pick
// Combinational rotating-priority picker. The search starts at i_start and
// wraps around; the first set request bit wins.
//   i_req    : request vector
//   i_start  : index with highest priority this cycle
//   o_onehot : one-hot winner (zero when nothing requests)
//   o_idx    : winner index (zero when nothing requests)
//   o_any    : at least one request bit set
// ---------------------------------------------------------------------------
module bus_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int off = 0; off < N; off++) begin
            logic [IW-1:0] w_idx;
            w_idx = IW'((int'(i_start) + off) % N);
            if (!o_any && i_req[w_idx]) begin
                o_any           = 1'b1;
                o_onehot[w_idx] = 1'b1;
                o_idx           = w_idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Single-owner arbiter for the shared memory bus. PWB requests outrank
// normal ones; masters of the same class are served round-robin. Every
// handover passes through one RELEASE (turnaround) cycle with no grant.
//   plusclk      : clock, rising edge
//   rst          : asynchronous active-high reset
//   bus_req      : per-master request (level)
//   bus_req_type : per-master class, 0 normal / 1 PWB
//   bus_hold     : owner keeps the bus while its bit is 1
//   bus_grant    : registered one-hot grant (or zero)
//   bus_active   : registered, high while any grant is high
//   bus_owner    : index of the current or last owner
//   hold_timeout : sticky, set when a tenure is cut at the hold limit
// ---------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = ARB_NUM_MASTERS,
    parameter int IDX_WIDTH   = ARB_IDX_WIDTH,
    parameter int HOLD_LIMIT  = ARB_HOLD_LIMIT
) (
    input  logic                   plusclk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] bus_req,
    input  logic [NUM_MASTERS-1:0] bus_req_type,
    input  logic [NUM_MASTERS-1:0] bus_hold,
    output logic [NUM_MASTERS-1:0] bus_grant,
    output logic                   bus_active,
    output logic [IDX_WIDTH-1:0]   bus_owner,
    output logic                   hold_timeout
);

    localparam int CW = cnt_width(HOLD_LIMIT);
    localparam logic [CW-1:0] TENURE_MAX = CW'(HOLD_LIMIT - 1);

    arb_state_t             r_state, w_state_next;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_next;
    logic                   r_active;
    logic [IDX_WIDTH-1:0]   r_owner, w_owner_next;
    logic [IDX_WIDTH-1:0]   r_rr_ptr, w_rr_next;
    logic [CW-1:0]          r_tenure, w_tenure_next;
    logic                   r_timeout, w_timeout_next;

    logic [NUM_MASTERS-1:0] w_pwb_req;
    logic [IDX_WIDTH-1:0]   w_start;
    logic [NUM_MASTERS-1:0] w_pwb_onehot, w_all_onehot, w_win_onehot;
    logic [IDX_WIDTH-1:0]   w_pwb_idx, w_all_idx, w_win_idx;
    logic                   w_pwb_any, w_all_any;
    logic                   w_owner_hold;

    // Class bits are meaningful only while the matching request is high.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_pwb
            assign w_pwb_req[gi] = bus_req[gi] && (bus_req_type[gi] == REQ_PWB);
        end
    endgenerate

    // Rotating priority begins one past the last winner.
    assign w_start = (r_rr_ptr == IDX_WIDTH'(NUM_MASTERS - 1)) ? '0 : r_rr_ptr + 1'b1;

    bus_arbiter_rr_pick #(.N(NUM_MASTERS), .IW(IDX_WIDTH)) u_pick_pwb (
        .i_req    (w_pwb_req),
        .i_start  (w_start),
        .o_onehot (w_pwb_onehot),
        .o_idx    (w_pwb_idx),
        .o_any    (w_pwb_any)
    );

    bus_arbiter_rr_pick #(.N(NUM_MASTERS), .IW(IDX_WIDTH)) u_pick_all (
        .i_req    (bus_req),
        .i_start  (w_start),
        .o_onehot (w_all_onehot),
        .o_idx    (w_all_idx),
        .o_any    (w_all_any)
    );

    assign w_win_onehot = w_pwb_any ? w_pwb_onehot : w_all_onehot;
    assign w_win_idx    = w_pwb_any ? w_pwb_idx    : w_all_idx;

    // Only the owner's hold bit matters; all others are ignored.
    assign w_owner_hold = bus_hold[r_owner];

    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_owner_next   = r_owner;
        w_rr_next      = r_rr_ptr;
        w_tenure_next  = r_tenure;
        w_timeout_next = r_timeout;
        case (r_state)
            ARB_IDLE, ARB_RELEASE: begin
                // w_all_any covers the PWB class too.
                if (w_all_any) begin
                    w_state_next  = ARB_GRANT;
                    w_grant_next  = w_win_onehot;
                    w_owner_next  = w_win_idx;
                    w_rr_next     = w_win_idx;
                    w_tenure_next = '0;
                end else begin
                    w_state_next = ARB_IDLE;
                    w_grant_next = '0;
                end
            end
            ARB_GRANT: begin
                if (!w_owner_hold || (r_tenure == TENURE_MAX)) begin
                    w_state_next = ARB_RELEASE;
                    w_grant_next = '0;
                    if (w_owner_hold) begin
                        w_timeout_next = 1'b1;
                    end
                end else begin
                    w_tenure_next = r_tenure + 1'b1;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge plusclk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_grant   <= '0;
            r_active  <= 1'b0;
            r_owner   <= '0;
            r_rr_ptr  <= IDX_WIDTH'(NUM_MASTERS - 1);
            r_tenure  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_grant   <= w_grant_next;
            r_active  <= |w_grant_next;
            r_owner   <= w_owner_next;
            r_rr_ptr  <= w_rr_next;
            r_tenure  <= w_tenure_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign bus_grant    = r_grant;
    assign bus_active   = r_active;
    assign bus_owner    = r_owner;
    assign hold_timeout = r_timeout;

endmodule
